core_seq_ctrl: RTL and testbench

- Multi-cycle sequencer wrapped around the instruction decoder and the single-cycle datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Gates the decoder's register-write and PC-advance effects so each takes effect only in the WB phase.
- Owns the data-memory request handshake, with a timeout.
- Sits between the instruction register/PC logic and the decoder-driven datapath.

---
 rtl/core_seq_pkg.sv | 62 ++++++
 rtl/core_seq_if.sv | 25 ++
 rtl/core_seq_tmo.sv | 32 +++
 rtl/core_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_core_seq_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared types and constants for the multi-cycle sequencer.
// Holds the FSM state encoding, the instruction-class enum, the opcode
// constants and the opcode classifier used in the DECODE phase.
package core_seq_pkg;

  // Sequencer states; encodings are visible on state_o for debug.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // Instruction classes that steer the EXEC/MEM/WB behaviour.
  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_ALU    = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4
  } iclass_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  // Result of classifying one opcode: legality flag plus its class.
  typedef struct packed {
    logic    legal;
    iclass_e cls;
  } dec_t;

  // Map an opcode onto its class; unknown opcodes come back not legal.
  function automatic dec_t classify(input logic [6:0] opc);
    dec_t d;
    d.legal = 1'b1;
    d.cls   = CLS_ALU;
    case (opc)
      OPC_LOAD:   d.cls = CLS_LOAD;
      OPC_STORE:  d.cls = CLS_STORE;
      OPC_OPIMM,
      OPC_OP,
      OPC_LUI,
      OPC_AUIPC:  d.cls = CLS_ALU;
      OPC_BRANCH: d.cls = CLS_BRANCH;
      OPC_JAL,
      OPC_JALR:   d.cls = CLS_JUMP;
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/core_seq_if.sv
// core_seq_if: data-memory request bus between the sequencer and memory.
//
// Handshake: dmem_req_o is held high for every cycle the sequencer waits in
// MEM (dmem_we_o qualifies it as a store). The request completes on the first
// rising edge at which dmem_ready_i is high while dmem_req_o is high; the
// request drops in the following cycle. Memory must not assume the request
// stays up after it has signalled ready, and a missing ready eventually ends
// the request through the sequencer's timeout trap.
interface core_seq_if;
  logic dmem_req_o;
  logic dmem_we_o;
  logic dmem_ready_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    input  dmem_ready_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    output dmem_ready_i
  );
endinterface

// File: rtl/core_seq_tmo.sv
// core_seq_tmo: memory-wait timeout counter.
// i_start reloads the count to zero (issued on the way into MEM); i_tick adds
// one per stalled cycle. o_expire is high once the count has reached
// MEM_TMO-1, i.e. on the MEM_TMO-th consecutive stalled MEM cycle.
module core_seq_tmo #(
  parameter int MEM_TMO = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_start,
  input  logic i_tick,
  output logic o_expire
);

  localparam logic [7:0] LAST = 8'(MEM_TMO - 1);

  logic [7:0] r_cnt;

  // Count stalled cycles; hold at LAST so the counter can never wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 8'd0;
    end else if (i_start) begin
      r_cnt <= 8'd0;
    end else if (i_tick && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Gates register-write and PC-advance so they only act in WB, owns the data
// memory request with a timeout trap, and counts retired instructions.
// Optional feature macro: CORE_SEQ_INSTRET_EN (retired-instruction counter);
// when it is undefined instret_o is tied to zero.
// All outputs decode registered state only, so no input reaches an output
// combinationally.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int MEM_TMO = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [6:0]       opcode_i,
  core_seq_if.master       dmem,
  output logic             ir_load_o,
  output logic             rf_wr_gate_o,
  output logic             pc_update_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  state_e  r_state;
  state_e  w_next_state;
  iclass_e r_class;
  dec_t    w_dec;
  logic    w_tmo_start;
  logic    w_tmo_tick;
  logic    w_tmo_expire;

  assign w_dec   = classify(opcode_i);
  assign state_o = r_state;

  core_seq_tmo #(
    .MEM_TMO (MEM_TMO)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_start  (w_tmo_start),
    .i_tick   (w_tmo_tick),
    .o_expire (w_tmo_expire)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction class, captured once per instruction at the end of DECODE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_class <= CLS_ALU;
    end else if ((r_state == S_DECODE) && w_dec.legal) begin
      r_class <= w_dec.cls;
    end
  end

  // Next-state logic and Moore output decode of the current state.
  always_comb begin
    w_next_state      = r_state;
    w_tmo_start       = 1'b0;
    w_tmo_tick        = 1'b0;
    ir_load_o         = 1'b0;
    rf_wr_gate_o      = 1'b0;
    pc_update_o       = 1'b0;
    dmem.dmem_req_o   = 1'b0;
    dmem.dmem_we_o    = 1'b0;
    busy_o            = 1'b1;
    err_o             = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (en_i) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        ir_load_o    = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_state = w_dec.legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        // Reload the timeout so MEM always starts counting from zero.
        w_tmo_start = 1'b1;
        if ((r_class == CLS_LOAD) || (r_class == CLS_STORE)) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        dmem.dmem_req_o = 1'b1;
        dmem.dmem_we_o  = (r_class == CLS_STORE);
        // Ready is checked first so a late ready beats the timeout.
        if (dmem.dmem_ready_i) begin
          w_next_state = S_WB;
        end else if (w_tmo_expire) begin
          w_next_state = S_TRAP;
        end else begin
          w_tmo_tick = 1'b1;
        end
      end
      S_WB: begin
        pc_update_o  = 1'b1;
        rf_wr_gate_o = (r_class == CLS_LOAD) || (r_class == CLS_ALU) ||
                       (r_class == CLS_JUMP);
        w_next_state = en_i ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        busy_o = 1'b0;
        err_o  = 1'b1;
        if (clear_i) w_next_state = S_IDLE;
      end
      default: begin
        busy_o       = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

`ifdef CORE_SEQ_INSTRET_EN
  logic [CNT_W-1:0] r_instret;

  // One increment per retired instruction, wrapping at 2^CNT_W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instret <= '0;
    end else if (r_state == S_WB) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret_o = r_instret;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: randomized self-checking bench for core_seq_ctrl.
// The reference model expands each instruction into its expected per-cycle
// output trace from the sequencing rules (phase order, memory wait length,
// timeout length, class effects); the bench replays the matching input
// stimulus and compares every cycle on the falling clock edge.
module tb_core_seq_ctrl;

  localparam int MEM_TMO = 4;
  localparam int CNT_W   = 8;
  localparam int W       = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic             en_i = 1'b0;
  logic             clear_i = 1'b0;
  logic [6:0]       opcode_i = 7'h00;
  logic             ir_load_o, rf_wr_gate_o, pc_update_o, busy_o, err_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instret_o;

  core_seq_if bus ();

  core_seq_ctrl #(
    .MEM_TMO (MEM_TMO),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .clear_i      (clear_i),
    .opcode_i     (opcode_i),
    .dmem         (bus),
    .ir_load_o    (ir_load_o),
    .rf_wr_gate_o (rf_wr_gate_o),
    .pc_update_o  (pc_update_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .state_o      (state_o),
    .instret_o    (instret_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [10:0]   drv_q[$];   // {opcode, wb, clear, en, ready}
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_retired = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected output vector {state, ir_load, rf_wr, pc_upd, req, we, busy, err}.
  function automatic logic [W-1:0] ev(input logic [2:0] st, input logic ir, input logic rf,
                                      input logic pc, input logic req, input logic we);
    logic busy, err;
    busy = (st != 3'd0) && (st != 3'd6);
    err  = (st == 3'd6);
    return {st, ir, rf, pc, req, we, busy, err};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {state_o, ir_load_o, rf_wr_gate_o, pc_update_o,
            bus.dmem_req_o, bus.dmem_we_o, busy_o, err_o};
  endfunction

  function automatic logic [CNT_W-1:0] exp_instret();
`ifdef CORE_SEQ_INSTRET_EN
    return CNT_W'(n_retired);
`else
    return '0;
`endif
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic [6:0] pick_opc();
    logic [6:0] legal_opc [9];
    int r;
    legal_opc = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67};
    r = $urandom_range(0, 10);
    if (r < 9) return legal_opc[r];
    return ro();
  endfunction

  // ---------------- reference model ----------------
  task automatic add(input logic [W-1:0] v, input logic rdy, input logic en,
                     input logic clr, input logic [6:0] opc, input logic wb);
    exp_q.push_back(v);
    drv_q.push_back({opc, wb, clr, en, rdy});
  endtask

  // Sticky trap: linger 0..2 cycles, clear, then one IDLE cycle that restarts.
  task automatic gen_trap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) add(ev(3'd6, 0, 0, 0, 0, 0), rb(), rb(), 1'b0, ro(), 1'b0);
    add(ev(3'd6, 0, 0, 0, 0, 0), rb(), rb(), 1'b1, ro(), 1'b0);
    add(ev(3'd0, 0, 0, 0, 0, 0), rb(), 1'b1, rb(), ro(), 1'b0);
  endtask

  // One instruction starting at FETCH. d = stalled cycles before ready
  // (d >= MEM_TMO means ready never comes). en_mode: 0 park, 1 continue, 2 random.
  task automatic gen_instr(input logic [6:0] opc, input int d, input int en_mode);
    logic legal, is_mem, is_st, rf, en_n;
    int   n;
    legal  = opc inside {7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67};
    is_mem = (opc == 7'h03) || (opc == 7'h23);
    is_st  = (opc == 7'h23);
    rf     = opc inside {7'h03, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67};
    add(ev(3'd1, 1, 0, 0, 0, 0), rb(), rb(), rb(), ro(), 1'b0);
    add(ev(3'd2, 0, 0, 0, 0, 0), rb(), rb(), rb(), opc, 1'b0);
    if (!legal) begin
      gen_trap();
      return;
    end
    add(ev(3'd3, 0, 0, 0, 0, 0), rb(), rb(), rb(), ro(), 1'b0);
    if (is_mem) begin
      for (int k = 0; k < MEM_TMO; k++) begin
        add(ev(3'd4, 0, 0, 0, 1, is_st), (k == d), rb(), rb(), ro(), 1'b0);
        if (k == d) break;
      end
      if (d >= MEM_TMO) begin
        gen_trap();
        return;
      end
    end
    en_n = (en_mode == 2) ? rb() : (en_mode == 1);
    add(ev(3'd5, 0, rf, 1, 0, 0), rb(), en_n, rb(), ro(), 1'b1);
    if (!en_n) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) add(ev(3'd0, 0, 0, 0, 0, 0), rb(), 1'b0, rb(), ro(), 1'b0);
      if (en_mode != 0) add(ev(3'd0, 0, 0, 0, 0, 0), rb(), 1'b1, rb(), ro(), 1'b0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drain();
    logic [W-1:0] v;
    logic [10:0]  d;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      v = exp_q.pop_front();
      d = drv_q.pop_front();
      check_eq("cycle_outputs", 32'(obs_vec()), 32'(v));
      check_eq("instret", 32'(instret_o), 32'(exp_instret()));
      if (d[3]) n_retired++;
      opcode_i         = d[10:4];
      clear_i          = d[2];
      en_i             = d[1];
      bus.dmem_ready_i = d[0];
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.dmem_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 32'(obs_vec()), 32'(0));
    check_eq("reset_instret", 32'(instret_o), 32'(0));
    rst_i = 1'b0;

    add(ev(3'd0, 0, 0, 0, 0, 0), rb(), 1'b0, rb(), ro(), 1'b0);
    add(ev(3'd0, 0, 0, 0, 0, 0), rb(), 1'b1, rb(), ro(), 1'b0);
    gen_instr(7'h13, 0, 1);             // ALU, 4 cycles
    gen_instr(7'h03, 3, 1);             // load, 3 wait cycles
    gen_instr(7'h23, 0, 1);             // store, immediate ready
    gen_instr(7'h63, 0, 1);             // branch, no register write
    gen_instr(7'h7F, 0, 1);             // illegal -> trap
    gen_instr(7'h03, MEM_TMO, 1);       // ready never comes -> timeout trap
    gen_instr(7'h03, MEM_TMO - 1, 2);   // ready on last allowed cycle
    drain();

    for (int i = 0; i < 150; i++) begin
      gen_instr(pick_opc(), $urandom_range(0, MEM_TMO + 1), 2);
    end
    gen_instr(7'h13, 0, 0);             // park in IDLE
    drain();

    // Asynchronous reset in the middle of a memory wait.
    add(ev(3'd0, 0, 0, 0, 0, 0), rb(), 1'b1, rb(), ro(), 1'b0);
    add(ev(3'd1, 1, 0, 0, 0, 0), rb(), rb(), rb(), ro(), 1'b0);
    add(ev(3'd2, 0, 0, 0, 0, 0), rb(), rb(), rb(), 7'h03, 1'b0);
    add(ev(3'd3, 0, 0, 0, 0, 0), rb(), rb(), rb(), ro(), 1'b0);
    add(ev(3'd4, 0, 0, 0, 1, 0), 1'b0, rb(), rb(), ro(), 1'b0);
    add(ev(3'd4, 0, 0, 0, 1, 0), 1'b0, rb(), rb(), ro(), 1'b0);
    drain();
    #2;
    check_eq("pre_reset_in_mem", 32'(state_o), 32'(4));
    rst_i = 1'b1;
    en_i  = 1'b0;
    #1;
    check_eq("async_reset_outputs", 32'(obs_vec()), 32'(0));
    check_eq("async_reset_instret", 32'(instret_o), 32'(0));
    n_retired = 0;
    #4;
    rst_i = 1'b0;

    add(ev(3'd0, 0, 0, 0, 0, 0), rb(), 1'b0, rb(), ro(), 1'b0);
    add(ev(3'd0, 0, 0, 0, 0, 0), rb(), 1'b1, rb(), ro(), 1'b0);
    gen_instr(7'h13, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
